// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the register-file write-port arbiter
package wb_arb_pkg;

    // One pending register-file write: destination and value
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } rf_wr_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Which source owns the write port this cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_FIFO = 2'd2
    } grant_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - write-back, multi-cycle result and register-file port bundle
interface wb_port_arbiter_if;

    logic        wb_regwrite;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;

    // Pipeline / multi-cycle unit side: offers writes, consumes port and stall
    modport master (
        output wb_regwrite, wb_addr, wb_data,
        output md_valid, md_addr, md_data,
        input  md_ready,
        input  rf_we, rf_waddr, rf_wdata, stall_req
    );

    // Arbiter side
    modport slave (
        input  wb_regwrite, wb_addr, wb_data,
        input  md_valid, md_addr, md_data,
        output md_ready,
        output rf_we, rf_waddr, rf_wdata, stall_req
    );

endinterface

// File: rtl/wb_port_arbiter_sync_fifo.sv
// rtl/wb_port_arbiter_sync_fifo.sv - synchronous FIFO with zero-latency head output
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt state
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state; power-of-two depth lets pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while count says the slot is free
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter between WB stage and mul/div results
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    rf_wr_t                  fifo_din;
    rf_wr_t                  fifo_head;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count_unused;

    logic [SW-1:0]           starve_q, starve_d;
    logic                    stall;
    logic                    wb_req;
    grant_e                  grant;

    assign fifo_din.addr = bus.md_addr;
    assign fifo_din.data = bus.md_data;

    // Ready depends only on registered occupancy: a same-cycle pop never opens a slot
    assign bus.md_ready = !rst && !fifo_full;
    assign fifo_push    = bus.md_valid && bus.md_ready;
    assign fifo_pop     = (grant == GNT_FIFO);

    assign wb_req       = bus.wb_regwrite && (bus.wb_addr != REG_ZERO);
    assign stall        = !rst && (starve_q == SW'(STARVE_LIMIT));
    assign bus.stall_req = stall;

    sync_fifo #(
        .WIDTH ($bits(rf_wr_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_unused)
    );

    // Grant selection: forced drain, then pipeline, then buffered results
    always_comb begin
        grant = GNT_NONE;
        if (rst)                      grant = GNT_NONE;
        else if (stall && !fifo_empty) grant = GNT_FIFO;
        else if (wb_req)               grant = GNT_WB;
        else if (!fifo_empty)          grant = GNT_FIFO;
    end

    // Drive the write port from the granted source; r0 heads are popped but not written
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        case (grant)
            GNT_WB: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = bus.wb_addr;
                bus.rf_wdata = bus.wb_data;
            end
            GNT_FIFO: begin
                bus.rf_we    = (fifo_head.addr != REG_ZERO);
                bus.rf_waddr = fifo_head.addr;
                bus.rf_wdata = fifo_head.data;
            end
            default: ;
        endcase
    end

    // Starvation count: cycles the FIFO head has lost to the pipeline, saturating
    always_comb begin
        starve_d = starve_q;
        if (grant == GNT_FIFO || fifo_empty)
            starve_d = '0;
        else if (grant == GNT_WB && starve_q != SW'(STARVE_LIMIT))
            starve_d = starve_q + SW'(1);
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                          input logic mv, input logic [4:0] ma, input logic [31:0] md);
        bus.wb_regwrite = wr;
        bus.wb_addr     = wa;
        bus.wb_data     = wd;
        bus.md_valid    = mv;
        bus.md_addr     = ma;
        bus.md_data     = md;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h1111_1111);
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            vectors++; if (bus.md_ready !== 1'b0) begin miscompares++; $display("FAIL reset_md_ready cyc%0d got %b exp 0", i, bus.md_ready); end
            vectors++; if (bus.rf_we !== 1'b0) begin miscompares++; $display("FAIL reset_rf_we cyc%0d got %b exp 0", i, bus.rf_we); end
            vectors++; if (bus.stall_req !== 1'b0) begin miscompares++; $display("FAIL reset_stall cyc%0d got %b exp 0", i, bus.stall_req); end
            vectors++; if (bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_port cyc%0d got %0d/%h exp 0/0", i, bus.rf_waddr, bus.rf_wdata); end
        end
        cyc();
        rst = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        vectors++; if (bus.md_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_md_ready got %b exp 1", bus.md_ready); end
        vectors++; if (bus.rf_we !== 1'b0) begin miscompares++; $display("FAIL post_reset_rf_we got %b exp 0", bus.rf_we); end
        vectors++; if (bus.stall_req !== 1'b0) begin miscompares++; $display("FAIL post_reset_stall got %b exp 0", bus.stall_req); end
        cyc();
        @(negedge clk);
        vectors++; if (bus.rf_we !== 1'b0) begin miscompares++; $display("FAIL post_reset_empty got rf_we %b exp 0", bus.rf_we); end
    endtask

    task automatic test_idle_drain();
        cyc();
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        vectors++; if (bus.md_ready !== 1'b1 || bus.rf_we !== 1'b0) begin miscompares++; $display("FAIL drain_accept got ready %b we %b exp 1 0", bus.md_ready, bus.rf_we); end
        cyc();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        vectors++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL drain_write got %b/%0d/%h exp 1/5/deadbeef", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        cyc();
        @(negedge clk);
        vectors++; if (bus.rf_we !== 1'b0) begin miscompares++; $display("FAIL drain_empty got rf_we %b exp 0", bus.rf_we); end
    endtask

    task automatic test_priority();
        cyc();
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h11);
        cyc();
        set_in(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'h33) begin
                miscompares++; $display("FAIL prio_wb cyc%0d got %b/%0d/%h exp 1/3/33", i, bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
            cyc();
        end
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        vectors++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'h11) begin
            miscompares++; $display("FAIL prio_fifo got %b/%0d/%h exp 1/7/11", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        cyc();
        @(negedge clk);
        vectors++; if (bus.rf_we !== 1'b0) begin miscompares++; $display("FAIL prio_empty got rf_we %b exp 0", bus.rf_we); end
    endtask

    task automatic test_starvation();
        cyc();
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h22);
        cyc();
        set_in(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++; if (bus.rf_waddr !== 5'd4 || bus.stall_req !== 1'b0 || bus.rf_we !== 1'b1) begin
                miscompares++; $display("FAIL starve_wb cyc%0d got addr %0d stall %b we %b exp 4 0 1", i, bus.rf_waddr, bus.stall_req, bus.rf_we); end
            cyc();
        end
        @(negedge clk);
        vectors++; if (bus.stall_req !== 1'b1) begin miscompares++; $display("FAIL starve_stall got %b exp 1", bus.stall_req); end
        vectors++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9 || bus.rf_wdata !== 32'h22) begin
            miscompares++; $display("FAIL starve_drain got %b/%0d/%h exp 1/9/22", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        cyc();
        @(negedge clk);
        vectors++; if (bus.stall_req !== 1'b0 || bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 32'h44) begin
            miscompares++; $display("FAIL starve_replay got stall %b addr %0d data %h exp 0 4 44", bus.stall_req, bus.rf_waddr, bus.rf_wdata); end
        cyc();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        vectors++; if (bus.rf_we !== 1'b0) begin miscompares++; $display("FAIL starve_empty got rf_we %b exp 0", bus.rf_we); end
    endtask

    task automatic test_full_and_r0();
        cyc();
        set_in(1'b1, 5'd6, 32'h66, 1'b1, 5'd0, 32'hAA);
        @(negedge clk);
        vectors++; if (bus.md_ready !== 1'b1) begin miscompares++; $display("FAIL full_acc0 got ready %b exp 1", bus.md_ready); end
        cyc();
        set_in(1'b1, 5'd6, 32'h66, 1'b1, 5'd10, 32'hBB);
        @(negedge clk);
        vectors++; if (bus.md_ready !== 1'b1 || bus.rf_waddr !== 5'd6) begin miscompares++; $display("FAIL full_acc1 got ready %b addr %0d exp 1 6", bus.md_ready, bus.rf_waddr); end
        cyc();
        set_in(1'b1, 5'd6, 32'h66, 1'b1, 5'd11, 32'hCC);
        @(negedge clk);
        vectors++; if (bus.md_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready got %b exp 0", bus.md_ready); end
        cyc();
        set_in(1'b1, 5'd0, 32'h77, 1'b1, 5'd11, 32'hCC);
        @(negedge clk);
        vectors++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0) begin miscompares++; $display("FAIL r0_pop got we %b addr %0d exp 0 0", bus.rf_we, bus.rf_waddr); end
        vectors++; if (bus.md_ready !== 1'b0) begin miscompares++; $display("FAIL no_fallthrough got ready %b exp 0", bus.md_ready); end
        cyc();
        set_in(1'b1, 5'd6, 32'h66, 1'b1, 5'd11, 32'hCC);
        @(negedge clk);
        vectors++; if (bus.md_ready !== 1'b1 || bus.rf_waddr !== 5'd6) begin miscompares++; $display("FAIL full_reopen got ready %b addr %0d exp 1 6", bus.md_ready, bus.rf_waddr); end
        cyc();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        vectors++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd10 || bus.rf_wdata !== 32'hBB) begin
            miscompares++; $display("FAIL full_drain0 got %b/%0d/%h exp 1/10/bb", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        cyc();
        @(negedge clk);
        vectors++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd11 || bus.rf_wdata !== 32'hCC) begin
            miscompares++; $display("FAIL full_drain1 got %b/%0d/%h exp 1/11/cc", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        cyc();
        @(negedge clk);
        vectors++; if (bus.rf_we !== 1'b0) begin miscompares++; $display("FAIL full_empty got rf_we %b exp 0", bus.rf_we); end
    endtask

    task automatic test_mid_reset();
        cyc();
        set_in(1'b1, 5'd6, 32'h66, 1'b1, 5'd12, 32'h12);
        cyc();
        set_in(1'b1, 5'd6, 32'h66, 1'b1, 5'd13, 32'h13);
        cyc();
        rst = 1'b1;
        set_in(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        vectors++; if (bus.rf_we !== 1'b0 || bus.md_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_hold got we %b ready %b exp 0 0", bus.rf_we, bus.md_ready); end
        cyc();
        rst = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++; if (bus.rf_we !== 1'b0 || bus.md_ready !== 1'b1 || bus.stall_req !== 1'b0) begin
                miscompares++; $display("FAIL midrst_dropped cyc%0d got we %b ready %b stall %b exp 0 1 0", i, bus.rf_we, bus.md_ready, bus.stall_req); end
            cyc();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        test_reset();
        test_idle_drain();
        test_priority();
        test_starvation();
        test_full_and_r0();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter for the single register-file write port at the end of the pipeline. The in-order write-back stage (MEM_WB output plus MemtoReg mux) competes with a multi-cycle unit (mul/div) for the port. The multi-cycle unit's results are buffered in a small FIFO. The pipeline has priority, and a starvation counter forces a one-cycle pipeline stall so buffered results drain.

## Interface
Parameters:
- DEPTH, 2, result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive lost cycles before a forced stall (≥1)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- wb_regwrite  in  1  WB stage requests a write (WB_RegWrite)
- wb_addr  in  5  WB destination register
- wb_data  in  32  WB write data (post MemtoReg mux)
- md_valid  in  1  multi-cycle unit offers a result
- md_addr  in  5  result destination register
- md_data  in  32  result data
- md_ready  out  1  FIFO can accept; a transfer occurs when md_valid && md_ready
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- stall_req  out  1  pipeline must freeze MEM_WB and re-present the same WB write next cycle

## Operation
- Write request: wb_req = wb_regwrite && wb_addr != 0. Address 0 writes are never performed.
- FIFO: DEPTH entries of {addr, data}, with a count register and wrapping read/write pointers. Pointer width is log2(DEPTH).
- Grant selection per cycle, in priority order:
  - rst = 1: no grant.
  - stall_req = 1 and FIFO non-empty: FIFO head granted. The WB write is ignored this cycle.
  - wb_req: WB granted.
  - FIFO non-empty: FIFO head granted.
  - Otherwise: no grant.
- Outputs:
  - rf_we = 1 when WB is granted, or when the FIFO head is granted and its addr != 0.
  - rf_waddr and rf_wdata come from the granted source. They are 0 when nothing is granted.
- Popping the FIFO head:
  - Any FIFO-head grant pops, including head entries with addr = 0, which are discarded silently.
- Pushing into the FIFO:
  - md_ready = (count < DEPTH), decoded from the registered count only.
  - When full, md_ready stays 0 even if a pop happens in the same cycle. There is no fall-through.
  - Push and pop in the same cycle leave count unchanged.
  - A pushed entry is never visible in the same cycle. The earliest it can be written is the next cycle.
- Starvation counter (saturating):
  - Reset to 0 on any FIFO-head grant or when the FIFO is empty.
  - Otherwise +1 per cycle in which the FIFO is non-empty and WB wins.
  - Saturates at STARVE_LIMIT.
- stall_req = (starve_cnt == STARVE_LIMIT), decoded from the register, so it is glitch-free.
  - It stays high for exactly one cycle, because the FIFO grant in that cycle clears the counter.
- No WAW or RAW ordering checks. The upstream scoreboard guarantees that a WB write and a pending result never target the same register.

## Timing
- Write-port outputs are combinational from the current inputs and state: zero-cycle latency for WB writes.
- A FIFO result is written at the earliest 1 cycle after acceptance.
  - Worst-case wait for the head entry is STARVE_LIMIT+1 cycles.
- Reset values, while rst is high and on the first cycle after it is released:
  - count = 0, pointers = 0, starve_cnt = 0.
  - md_ready = 0 while rst is high, then 1.
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0, stall_req = 0.
- Reset mid-operation: buffered results are dropped. The multi-cycle unit is reset by the same rst.
- stall_req asserted in cycle N means the pipeline holds MEM_WB at the edge ending cycle N.
  - The ignored WB write reappears in cycle N+1 and wins there.

## Structure
- Shared package `wb_arb_pkg`: typedef `rf_wr_t` {addr[4:0], data[31:0]}, constant `REG_ZERO = 5'd0`.
- One sub-module, `sync_fifo`, parameterised by width and depth.
  - Signals: push/pop/full/empty/count, head output without read latency.
- Arbitration logic and the starvation counter stay in the top module.

## Test plan
- Reset: hold rst for 3 cycles with md_valid = 1 → md_ready = 0, rf_we = 0, stall_req = 0, and FIFO stays empty afterward.
- Idle drain: push {r5, 0xDEADBEEF} with wb_regwrite = 0 → in the next cycle, rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF; FIFO then empty.
- Priority: push {r7, 0x11}, then hold wb_regwrite = 1 to r3 for 2 cycles → WB writes r3 both cycles, then r7 = 0x11 is written in the cycle WB goes idle.
- Starvation: push {r9, 0x22}, then wb_regwrite = 1 to r4 continuously → WB wins 4 cycles; stall_req = 1 in the 5th cycle with r9 written; then r4 is written again in the 6th cycle with stall_req = 0.
- Full and $0: with DEPTH = 2, offer 3 results while WB is busy → md_ready goes 0 after 2 accepts. A result to r0 pops with rf_we = 0. A WB write to r0 gives rf_we = 0 and the FIFO head is granted instead.
- Mid-operation reset: 2 entries buffered, assert rst for 1 cycle → no rf_we for dropped entries, and count = 0 afterward.
